johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
Receive-side companion to the 4-bit Johnson counter. Samples a Johnson-coded state bus and decodes it to a binary index and a one-hot vector. Checks each legal code against the previous one and flags illegal codes, skipped states and held states. Asserts a lock indication once the sequence advances cleanly.

Parameters:
N, 4, Johnson code width. Sequence length is 2N; must be >= 2.
LOCK_COUNT, 3, consecutive +1 steps required to assert locked; must be >= 1.
ERR_W, 8, width of the saturating error counter.
IW (local), clog2(2N), index width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
code_in  in  N  Johnson code sample
code_valid  in  1  code_in is sampled on this edge
idx  out  IW  decoded state index 0..2N-1
onehot  out  2N  onehot[idx] set for a legal sample
idx_valid  out  1  pulse: last sample legal
illegal  out  1  pulse: last sample not a Johnson code
step_ok  out  1  pulse: idx = previous legal idx + 1 mod 2N
skip  out  1  pulse: legal sample, neither +1 nor equal to previous
hold  out  1  pulse: legal sample equal to previous
locked  out  1  level: sequence tracking established
err_count  out  ERR_W  saturating count of illegal and skip events

Behaviour:
- Reset: all outputs 0; FSM = SEARCH; consecutive-step counter = 0; stored previous index cleared. Reset dominates code_valid.
- All outputs are registered. Results for a sample taken at edge k appear after edge k (1-cycle latency).
- Pulse flags (idx_valid, illegal, step_ok, skip, hold) are high for exactly one cycle per sample and are 0 in cycles with no sample.
- code_valid=0: no state change; idx, onehot, locked and err_count hold; pulse flags 0.
- Legal codes, MSB first:
  - 1^a 0^(N-a), a=1..N, decodes to idx = a-1.
  - 0^b 1^(N-b), b=1..N, decodes to idx = N+b-1.
  - For N=4 the sequence is 1000=0, 1100=1, 1110=2, 1111=3, 0111=4, 0011=5, 0001=6, 0000=7, then wraps to 1000.
- Every other pattern is illegal:
  - illegal=1; onehot=0; idx holds its last value.
  - err_count increments; FSM goes to SEARCH; step counter and stored previous index are cleared.
- FSM:
  - SEARCH: a legal sample sets idx_valid, stores the index, goes to TRACK. No step/skip/hold flag is raised.
  - TRACK:
    - step_ok increments the step counter. If the counter reaches LOCK_COUNT, go to LOCKED and assert locked in the same cycle as that step_ok.
    - hold changes neither the counter nor the state.
    - skip increments err_count, clears the counter, and stays in TRACK with the new index stored.
  - LOCKED:
    - step_ok and hold keep the lock.
    - skip increments err_count, deasserts locked, clears the counter, goes to TRACK.
    - illegal goes to SEARCH and deasserts locked.
- Wrap: index 2N-1 followed by index 0 is step_ok.
- err_count saturates at 2^ERR_W-1 and never wraps.
- The previous-index reference is kept across code_valid gaps. Step checking spans gaps.
- Reset mid-stream: outputs read 0 after the reset edge. The first sample after reset is treated as in SEARCH.

Test Plan:
1. N=4, LOCK_COUNT=3. After reset, apply 1000,1100,1110,1111,0111,0011,0001,0000,1000 on consecutive edges with code_valid=1.
   -> idx 0..7 then 0, onehot matching, idx_valid every cycle.
   -> step_ok from the second sample on, including 0000->1000.
   -> locked rises with the step_ok for 1111 and stays high; err_count=0.
2. While locked, apply 1010, then 0011,0001,0000,1000.
   -> illegal=1, onehot=0, idx held, err_count=1, locked=0.
   -> 0011 gives idx=5 with idx_valid and no step flag.
   -> relock on the step_ok for 1000.
3. While locked, apply 1100 then 1111.
   -> skip=1, err_count+1, locked=0.
   -> the following 0111,0011,0001 relock on the third step_ok.
4. While locked, apply 1110 twice.
   -> hold=1 on the second sample; locked stays 1; err_count unchanged.
5. Apply 1000, then 3 cycles of code_valid=0, then 1100.
   -> no flags during the gap, idx held at 0, then step_ok with idx=1.
   -> Also: rst for 1 cycle while locked with code_valid=1 -> all outputs 0 next cycle, no decode.
6. ERR_W=2: apply 5 illegal samples.
   -> err_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a sampled N-bit Johnson code into an index and a
// one-hot vector, checks each legal sample against the previous legal index,
// and raises a lock indication after LOCK_COUNT consecutive +1 steps.
module johnson_decoder #(
  parameter  int N          = 4,
  parameter  int LOCK_COUNT = 3,
  parameter  int ERR_W      = 8,
  localparam int IW         = $clog2(2 * N),
  localparam int CW         = $clog2(LOCK_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_valid,
  output logic [IW-1:0]    idx,
  output logic [2*N-1:0]   onehot,
  output logic             idx_valid,
  output logic             illegal,
  output logic             step_ok,
  output logic             skip,
  output logic             hold,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {legal, index}. A shifted all-ones mask gives 0^a 1^(N-a);
  // its complement gives 1^a 0^(N-a).
  function automatic logic [IW:0] decode_code(input logic [N-1:0] c);
    logic [IW:0]  r;
    logic [N-1:0] ones;
    r    = {(IW + 1){1'b0}};
    ones = {N{1'b1}};
    for (int a = 1; a <= N; a++) begin
      if (c == ~(ones >> a)) r = {1'b1, IW'(a - 1)};
      if (c == (ones >> a))  r = {1'b1, IW'(N + a - 1)};
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    prev_q, prev_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2*N-1:0]   onehot_q, onehot_d;
  logic             idx_valid_q, idx_valid_d;
  logic             illegal_q, illegal_d;
  logic             step_ok_q, step_ok_d;
  logic             skip_q, skip_d;
  logic             hold_q, hold_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [IW:0]      dec_s;
  logic             legal_s;
  logic [IW-1:0]    dec_idx_s;
  logic [IW-1:0]    next_idx_s;
  logic             is_step_s;
  logic             is_hold_s;
  logic [ERR_W-1:0] err_inc_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             reach_lock_s;

  // Decode the sample, classify it against the previous index and compute next state.
  always_comb begin
    dec_s        = decode_code(code_in);
    legal_s      = dec_s[IW];
    dec_idx_s    = dec_s[IW-1:0];
    next_idx_s   = (prev_q == IW'(2 * N - 1)) ? {IW{1'b0}} : prev_q + {{(IW-1){1'b0}}, 1'b1};
    is_step_s    = (dec_idx_s == next_idx_s);
    is_hold_s    = (dec_idx_s == prev_q);
    err_inc_s    = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    cnt_inc_s    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    reach_lock_s = (int'(cnt_inc_s) >= LOCK_COUNT);

    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    onehot_d    = onehot_q;
    err_d       = err_q;
    idx_valid_d = 1'b0;
    illegal_d   = 1'b0;
    step_ok_d   = 1'b0;
    skip_d      = 1'b0;
    hold_d      = 1'b0;

    if (code_valid) begin
      if (!legal_s) begin
        illegal_d = 1'b1;
        onehot_d  = {(2*N){1'b0}};
        err_d     = err_inc_s;
        state_d   = SEARCH;
        cnt_d     = {CW{1'b0}};
        prev_d    = {IW{1'b0}};
      end else begin
        idx_valid_d = 1'b1;
        idx_d       = dec_idx_s;
        onehot_d    = {{(2*N-1){1'b0}}, 1'b1} << dec_idx_s;
        prev_d      = dec_idx_s;
        case (state_q)
          SEARCH: begin
            state_d = TRACK;
            cnt_d   = {CW{1'b0}};
          end
          TRACK: begin
            if (is_step_s) begin
              step_ok_d = 1'b1;
              cnt_d     = cnt_inc_s;
              if (reach_lock_s) begin
                state_d = LOCKED;
              end else begin
                state_d = TRACK;
              end
            end else if (is_hold_s) begin
              hold_d = 1'b1;
            end else begin
              skip_d = 1'b1;
              err_d  = err_inc_s;
              cnt_d  = {CW{1'b0}};
            end
          end
          LOCKED: begin
            if (is_step_s) begin
              step_ok_d = 1'b1;
            end else if (is_hold_s) begin
              hold_d = 1'b1;
            end else begin
              skip_d  = 1'b1;
              err_d   = err_inc_s;
              cnt_d   = {CW{1'b0}};
              state_d = TRACK;
            end
          end
          default: begin
            state_d = SEARCH;
            cnt_d   = {CW{1'b0}};
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      cnt_q       <= {CW{1'b0}};
      prev_q      <= {IW{1'b0}};
      idx_q       <= {IW{1'b0}};
      onehot_q    <= {(2*N){1'b0}};
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      step_ok_q   <= 1'b0;
      skip_q      <= 1'b0;
      hold_q      <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= {ERR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      onehot_q    <= onehot_d;
      idx_valid_q <= idx_valid_d;
      illegal_q   <= illegal_d;
      step_ok_q   <= step_ok_d;
      skip_q      <= skip_d;
      hold_q      <= hold_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign idx       = idx_q;
  assign onehot    = onehot_q;
  assign idx_valid = idx_valid_q;
  assign illegal   = illegal_q;
  assign step_ok   = step_ok_q;
  assign skip      = skip_q;
  assign hold      = hold_q;
  assign locked    = locked_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder: two instances share the stimulus
// (LOCK_COUNT=3/ERR_W=8 and LOCK_COUNT=1/ERR_W=2); a sequence-level model
// pushes expected outputs, a monitor pops and compares every cycle.
module tb_johnson_decoder;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       iv;
    logic       il;
    logic       st;
    logic       sk;
    logic       ho;
    logic       lk;
    logic [7:0] err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = 4'b0000;
  logic       code_valid = 1'b0;

  logic [2:0] idx_a, idx_b;
  logic [7:0] oh_a, oh_b;
  logic       iv_a, il_a, st_a, sk_a, ho_a, lk_a;
  logic       iv_b, il_b, st_b, sk_b, ho_b, lk_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  johnson_decoder #(.N(4), .LOCK_COUNT(3), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .idx(idx_a), .onehot(oh_a), .idx_valid(iv_a), .illegal(il_a),
    .step_ok(st_a), .skip(sk_a), .hold(ho_a), .locked(lk_a), .err_count(err_a)
  );

  johnson_decoder #(.N(4), .LOCK_COUNT(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .idx(idx_b), .onehot(oh_b), .idx_valid(iv_b), .illegal(il_b),
    .step_ok(st_b), .skip(sk_b), .hold(ho_b), .locked(lk_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t q_exp[2][$];

  // Reference model state, per instance
  logic [3:0] jt[8];
  int   m_mode[2];   // 0 searching, 1 tracking, 2 locked
  int   m_prev[2];
  int   m_steps[2];
  int   m_err[2];
  obs_t m_out[2];
  int   lc[2]   = '{3, 1};
  int   emax[2] = '{255, 3};

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (jt[i] == c) return i;
    return -1;
  endfunction

  task automatic model(input logic r, input logic v, input logic [3:0] c);
    int k;
    for (int m = 0; m < 2; m++) begin
      if (r) begin
        m_mode[m] = 0; m_prev[m] = 0; m_steps[m] = 0; m_err[m] = 0;
        m_out[m] = '0;
      end else begin
        m_out[m].iv = 1'b0; m_out[m].il = 1'b0; m_out[m].st = 1'b0;
        m_out[m].sk = 1'b0; m_out[m].ho = 1'b0;
        if (v) begin
          k = lookup(c);
          if (k < 0) begin
            m_out[m].il = 1'b1;
            m_out[m].onehot = 8'h00;
            if (m_err[m] < emax[m]) m_err[m]++;
            m_mode[m] = 0; m_steps[m] = 0; m_prev[m] = 0;
          end else begin
            m_out[m].iv = 1'b1;
            m_out[m].idx = 3'(k);
            m_out[m].onehot = 8'(1 << k);
            if (m_mode[m] == 0) begin
              m_mode[m] = 1;
            end else if (k == (m_prev[m] + 1) % 8) begin
              m_out[m].st = 1'b1;
              if (m_mode[m] == 1) begin
                m_steps[m]++;
                if (m_steps[m] >= lc[m]) m_mode[m] = 2;
              end
            end else if (k == m_prev[m]) begin
              m_out[m].ho = 1'b1;
            end else begin
              m_out[m].sk = 1'b1;
              if (m_err[m] < emax[m]) m_err[m]++;
              m_steps[m] = 0;
              m_mode[m] = 1;
            end
            m_prev[m] = k;
          end
        end
        m_out[m].lk = (m_mode[m] == 2);
        m_out[m].err = 8'(m_err[m]);
      end
      q_exp[m].push_back(m_out[m]);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rst = r; code_valid = v; code_in = c;
    model(r, v, c);
  endtask

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q_exp[0].size() > 0) cmp("inst_a", {idx_a, oh_a, iv_a, il_a, st_a, sk_a, ho_a, lk_a, err_a}, q_exp[0].pop_front());
    if (q_exp[1].size() > 0) cmp("inst_b", {idx_b, oh_b, iv_b, il_b, st_b, sk_b, ho_b, lk_b, 6'd0, err_b}, q_exp[1].pop_front());
  end

  task automatic seq_full();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, jt[i]);
    cyc(1'b0, 1'b1, jt[0]);
  endtask

  initial begin
    logic [3:0] c;
    int cur, r;
    c = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      jt[i] = c;
      c = {~c[0], c[3:1]};
    end

    // Reset
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b1, 1'b1, 4'b1000);
    // 1: full sequence with wrap
    seq_full();
    // 2: illegal while locked, then resync and relock
    cyc(1'b0, 1'b1, 4'b1010);
    cyc(1'b0, 1'b1, 4'b0011);
    cyc(1'b0, 1'b1, 4'b0001);
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b1000);
    // 3: skip while locked, relock
    cyc(1'b0, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b1111);
    cyc(1'b0, 1'b1, 4'b0111);
    cyc(1'b0, 1'b1, 4'b0011);
    cyc(1'b0, 1'b1, 4'b0001);
    // 4: hold while locked
    cyc(1'b0, 1'b1, 4'b0000);
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b1110);
    cyc(1'b0, 1'b1, 4'b1110);
    // 5: gap spanning step check, then reset while locked
    cyc(1'b0, 1'b1, 4'b1000);
    cyc(1'b0, 1'b0, 4'b0101);
    cyc(1'b0, 1'b0, 4'b1111);
    cyc(1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b1100);
    seq_full();
    cyc(1'b1, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 4'b1110);
    cyc(1'b0, 1'b1, 4'b1111);
    // 6: saturation on the 2-bit instance
    cyc(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 4'b0100);

    // Randomized traffic
    cur = 0;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        cur = (cur + 1) % 8;
        cyc(1'b0, 1'b1, jt[cur]);
      end else if (r < 70) begin
        cyc(1'b0, 1'b1, jt[cur]);
      end else if (r < 80) begin
        cur = $urandom_range(0, 7);
        cyc(1'b0, 1'b1, jt[cur]);
      end else if (r < 88) begin
        cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      end else if (r < 97) begin
        cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      end else begin
        cyc(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (q_exp[0].size() != 0 || q_exp[1].size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d/%0d pending required 0/0", q_exp[0].size(), q_exp[1].size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
